// File: rtl/acc_shift_serial.sv
// acc_shift_serial: serial accumulator shifter feeding a bit-serial adder.
// Captures one WORD_LEN-bit word LSB first and holds it until the next
// word_start. At that word_start the word is shifted in parallel into the
// output buffer, then emitted LSB first on adder_a.
// Optional macro ACC_SHIFT_ROUND_EN adds round-half-up on right shifts. The
// rounding bit is added serially through a carry flop as the word is emitted.
module acc_shift_serial #(
  parameter int WORD_LEN  = 17,
  parameter int MAX_SHIFT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           acc_in,
  input  logic                           word_start,
  input  logic [$clog2(MAX_SHIFT+1)-1:0] shift_amt,
  input  logic                           shift_left,
  output logic                           adder_a,
  output logic                           out_start,
  output logic                           out_valid,
  output logic                           frame_err
);

  localparam int SW = $clog2(MAX_SHIFT + 1);
  localparam int CW = $clog2(WORD_LEN + 1);
  localparam int OW = $clog2(WORD_LEN);

  // capture side
  logic [WORD_LEN-1:0] cap_q, cap_d;
  logic [CW-1:0]       cap_cnt_q, cap_cnt_d;
  logic                cap_act_q, cap_act_d;
  logic [SW-1:0]       cap_amt_q, cap_amt_d;
  logic                cap_left_q, cap_left_d;

  // output side
  logic [WORD_LEN-1:0] out_q, out_d;
  logic [OW-1:0]       out_cnt_q, out_cnt_d;
  logic                out_act_q, out_act_d;
  logic                frame_err_q, frame_err_d;

  logic                cap_full;
  logic                xfer;
  logic                early;
  logic [SW-1:0]       amt_clamped;
  logic [WORD_LEN-1:0] shifted;
  logic                carry_in;

`ifdef ACC_SHIFT_ROUND_EN
  logic                carry_q, carry_d;
  logic [WORD_LEN-1:0] rnd_vec;
  logic                rnd_bit;
`endif

  assign cap_full = cap_act_q && (cap_cnt_q == CW'(WORD_LEN));
  assign xfer     = word_start && cap_full;
  assign early    = word_start && cap_act_q && !cap_full;

  // Out-of-range distances saturate here, so the captured word only ever sees legal amounts.
  assign amt_clamped = (shift_amt > SW'(MAX_SHIFT)) ? SW'(MAX_SHIFT) : shift_amt;

  // Parallel shift of the completed capture using that word's own latched shift.
  always_comb begin
    shifted = '0;
    if (cap_left_q) begin
      shifted = cap_q << cap_amt_q;
    end else begin
      shifted = $signed(cap_q) >>> cap_amt_q;
    end
  end

`ifdef ACC_SHIFT_ROUND_EN
  // Rounding bit is input bit n-1. It exists only for right shifts with n >= 1.
  always_comb begin
    rnd_vec = cap_q >> (cap_amt_q - SW'(1));
    rnd_bit = !cap_left_q && (cap_amt_q != '0) && rnd_vec[0];
  end
  assign carry_in = carry_q;
`else
  assign carry_in = 1'b0;
`endif

  assign out_valid = out_act_q;
  assign out_start = out_act_q && (out_cnt_q == '0);
  assign adder_a   = out_act_q && (out_q[0] ^ carry_in);
  assign frame_err = frame_err_q;

  // Next-state logic for the capture buffer, the output shifter and the framing pulse.
  always_comb begin
    cap_d       = cap_q;
    cap_cnt_d   = cap_cnt_q;
    cap_act_d   = cap_act_q;
    cap_amt_d   = cap_amt_q;
    cap_left_d  = cap_left_q;
    out_d       = out_q;
    out_cnt_d   = out_cnt_q;
    out_act_d   = out_act_q;
    frame_err_d = early;
`ifdef ACC_SHIFT_ROUND_EN
    carry_d     = carry_q;
`endif

    // Capture: word_start restarts at bit 0; bits beyond WORD_LEN are dropped.
    if (word_start) begin
      cap_d      = '0;
      cap_d[0]   = acc_in;
      cap_cnt_d  = CW'(1);
      cap_act_d  = 1'b1;
      cap_amt_d  = amt_clamped;
      cap_left_d = shift_left;
    end else if (cap_act_q && !cap_full) begin
      for (int unsigned i = 0; i < WORD_LEN; i++) begin
        if (cap_cnt_q == CW'(i)) begin
          cap_d[i] = acc_in;
        end
      end
      cap_cnt_d = cap_cnt_q + CW'(1);
    end

    // Output: a transfer reloads the buffer. Otherwise the buffer shifts until WORD_LEN bits are out.
    if (xfer) begin
      out_d     = shifted;
      out_cnt_d = '0;
      out_act_d = 1'b1;
`ifdef ACC_SHIFT_ROUND_EN
      carry_d   = rnd_bit;
`endif
    end else if (out_act_q) begin
      out_d = out_q >> 1;
`ifdef ACC_SHIFT_ROUND_EN
      carry_d = out_q[0] & carry_q;
`endif
      if (out_cnt_q == OW'(WORD_LEN - 1)) begin
        out_act_d = 1'b0;
        out_cnt_d = '0;
      end else begin
        out_cnt_d = out_cnt_q + OW'(1);
      end
    end
  end

  // State registers with synchronous reset. Reset also discards any word_start in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q       <= '0;
      cap_cnt_q   <= '0;
      cap_act_q   <= 1'b0;
      cap_amt_q   <= '0;
      cap_left_q  <= 1'b0;
      out_q       <= '0;
      out_cnt_q   <= '0;
      out_act_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef ACC_SHIFT_ROUND_EN
      carry_q     <= 1'b0;
`endif
    end else begin
      cap_q       <= cap_d;
      cap_cnt_q   <= cap_cnt_d;
      cap_act_q   <= cap_act_d;
      cap_amt_q   <= cap_amt_d;
      cap_left_q  <= cap_left_d;
      out_q       <= out_d;
      out_cnt_q   <= out_cnt_d;
      out_act_q   <= out_act_d;
      frame_err_q <= frame_err_d;
`ifdef ACC_SHIFT_ROUND_EN
      carry_q     <= carry_d;
`endif
    end
  end

endmodule

// File: tb/tb_acc_shift_serial.sv
// Bench for acc_shift_serial. A driver issues directed words and pushes the
// expected output words and frame_err cycles into queues. A negedge monitor
// pops those queues and compares them against what the DUT presents.
module tb_acc_shift_serial;

  localparam int WL = 17;

`ifdef ACC_SHIFT_ROUND_EN
  localparam logic [16:0] E_RND3 = 17'h00002;
  localparam logic [16:0] E_NEG5 = 17'h1FF88;
`else
  localparam logic [16:0] E_RND3 = 17'h00001;
  localparam logic [16:0] E_NEG5 = 17'h1FF87;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       acc_in = 1'b0;
  logic       word_start = 1'b0;
  logic [4:0] shift_amt = '0;
  logic       shift_left = 1'b0;
  logic       adder_a, out_start, out_valid, frame_err;

  acc_shift_serial #(.WORD_LEN(17), .MAX_SHIFT(16)) dut (
    .clk(clk), .rst(rst), .acc_in(acc_in), .word_start(word_start),
    .shift_amt(shift_amt), .shift_left(shift_left), .adder_a(adder_a),
    .out_start(out_start), .out_valid(out_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [16:0] w;
    int          start;
    int          nbits;
  } exp_t;

  exp_t        oq[$];
  int          feq[$];
  int          tests = 0;
  int          fails = 0;
  bit          pend_ok = 1'b0;
  bit          pend_part = 1'b0;
  logic [16:0] pend_exp = '0;
  int          next_nbits = WL;

  bit          in_word = 1'b0;
  int          idx = 0;
  logic [16:0] got = '0;
  exp_t        cur;
  int          idle_viol = 0;

  // Monitor: frame_err pulses, word boundaries, bit collection and idle-zero rule.
  always @(negedge clk) begin
    int          e;
    logic [16:0] mask;
    if (frame_err) begin
      tests++;
      if (feq.size() == 0) begin
        fails++;
        $display("FAIL frame_err_unexpected cyc=%0d got=1 required=0", cyc);
      end else begin
        e = feq.pop_front();
        if (e != cyc) begin
          fails++;
          $display("FAIL frame_err_cycle got=%0d required=%0d", cyc, e);
        end
      end
    end
    if (!out_valid) begin
      if (adder_a) idle_viol++;
      if (in_word) begin
        in_word = 1'b0;
        tests++;
        mask = (17'h1 << idx) - 17'h1;
        if (idx != cur.nbits || ((got ^ cur.w) & mask) != '0) begin
          fails++;
          $display("FAIL word_truncated bits got=%0d required=%0d data got=%h required=%h",
                   idx, cur.nbits, got & mask, cur.w & mask);
        end
      end
    end else begin
      if (out_start) begin
        if (in_word) begin
          tests++;
          fails++;
          $display("FAIL word_short bits got=%0d required=%0d", idx, cur.nbits);
          in_word = 1'b0;
        end
        tests++;
        if (oq.size() == 0) begin
          fails++;
          $display("FAIL out_unexpected cyc=%0d got=out_start required=idle", cyc);
        end else begin
          cur = oq.pop_front();
          if (cyc != cur.start) begin
            fails++;
            $display("FAIL out_latency start got=%0d required=%0d", cyc, cur.start);
          end
          in_word = 1'b1;
          idx = 0;
          got = '0;
        end
      end else if (!in_word) begin
        tests++;
        fails++;
        $display("FAIL stray_valid cyc=%0d got=1 required=0", cyc);
      end
      if (in_word) begin
        got[idx] = adder_a;
        idx++;
        if (idx == WL) begin
          in_word = 1'b0;
          tests++;
          if (cur.nbits != WL || got != cur.w) begin
            fails++;
            $display("FAIL word_data got=%h required=%h (bits required=%0d)", got, cur.w, cur.nbits);
          end
        end
      end
    end
  end

  // Drive nbits of w, starting with word_start. Shift inputs are scrambled on non-start cycles.
  task automatic drive_word(input logic [16:0] w, input int nbits, input logic [4:0] amt,
                            input bit left, input logic [16:0] expv);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      acc_in     = w[i];
      word_start = (i == 0);
      shift_amt  = (i == 0) ? amt : ~amt;
      shift_left = (i == 0) ? left : ~left;
      if (i == 0) begin
        if (pend_ok) oq.push_back('{pend_exp, cyc + 1, next_nbits});
        else if (pend_part) feq.push_back(cyc + 1);
        next_nbits = WL;
      end
    end
    pend_ok   = (nbits == WL);
    pend_part = (nbits < WL);
    pend_exp  = expv;
  endtask

  // Cycles with no word_start; acc_in held high to show surplus bits are ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      word_start = 1'b0;
      acc_in     = 1'b1;
      shift_amt  = 5'd7;
      shift_left = 1'b1;
    end
  endtask

  // Reset with a coincident word_start; every output must read 0 after each reset edge.
  task automatic apply_reset(input int n);
    @(posedge clk); #1;
    rst        = 1'b1;
    word_start = 1'b1;
    acc_in     = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({adder_a, out_start, out_valid, frame_err} != 4'b0000) begin
        fails++;
        $display("FAIL reset_outputs got=%b required=0000", {adder_a, out_start, out_valid, frame_err});
      end
    end
    rst        = 1'b0;
    word_start = 1'b0;
    acc_in     = 1'b0;
    pend_ok    = 1'b0;
    pend_part  = 1'b0;
  endtask

  initial begin
    apply_reset(3);
    drive_word(17'h00005, WL, 5'd2,  1'b1, 17'h00014);
    drive_word(17'h10000, WL, 5'd1,  1'b0, 17'h18000);
    drive_word(17'h10000, WL, 5'd20, 1'b0, 17'h1FFFF);
    drive_word(17'h00003, WL, 5'd1,  1'b0, E_RND3);
    drive_word(17'h1FFFF, 9,  5'd0,  1'b0, 17'h00000);
    drive_word(17'h00001, WL, 5'd0,  1'b0, 17'h00001);
    drive_word(17'h0ABCD, WL, 5'd0,  1'b0, 17'h0ABCD);
    drive_word(17'h12345, WL, 5'd3,  1'b1, 17'h11A28);
    drive_word(17'h1F0F0, WL, 5'd5,  1'b0, E_NEG5);
    drive_word(17'h00001, WL, 5'd16, 1'b1, 17'h10000);
    idle(3);
    drive_word(17'h0AAAA, WL, 5'd0,  1'b0, 17'h0AAAA);
    next_nbits = 7;
    drive_word(17'h15555, 7,  5'd0,  1'b0, 17'h00000);
    apply_reset(2);
    drive_word(17'h00007, WL, 5'd0,  1'b0, 17'h00007);
    idle(20);
    drive_word(17'h00000, WL, 5'd0,  1'b0, 17'h00000);
    idle(25);
    tests++;
    if (oq.size() != 0) begin
      fails++;
      $display("FAIL words_missing got=%0d required=0", oq.size());
    end
    tests++;
    if (feq.size() != 0) begin
      fails++;
      $display("FAIL frame_err_missing got=%0d required=0", feq.size());
    end
    tests++;
    if (idle_viol != 0) begin
      fails++;
      $display("FAIL adder_a_idle got=%0d required=0", idle_viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
